// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing defaults, colour type and PMOD pin packing.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int COLOR_W = 6;
    typedef logic [COLOR_W-1:0] color_t;

    // Idle PMOD value: both syncs deasserted (high), colour black.
    localparam logic [7:0] PMOD_RESET = 8'b1000_1000;

    typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;

    // Pin order {hsync,b0,g0,r0,vsync,b1,g1,r1} from colour {r1,r0,g1,g0,b1,b0}.
    function automatic logic [7:0] pack_pmod(input logic hs, input logic vs, input color_t c);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with sync decode and an end-of-frame strobe.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE      = VGA_H_ACTIVE,
    parameter int H_FRONT_PORCH = VGA_H_FP,
    parameter int H_SYNC_PULSE  = VGA_H_SYNC,
    parameter int H_TOTAL       = VGA_H_TOTAL,
    parameter int V_ACTIVE      = VGA_V_ACTIVE,
    parameter int V_FRONT_PORCH = VGA_V_FP,
    parameter int V_SYNC_PULSE  = VGA_V_SYNC,
    parameter int V_TOTAL       = VGA_V_TOTAL,
    parameter int X_BITS        = $clog2(H_TOTAL),
    parameter int Y_BITS        = $clog2(V_TOTAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [X_BITS-1:0] pixel_x,
    output logic [Y_BITS-1:0] pixel_y,
    output logic              active,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_wrap
);

    localparam int HS_START = H_ACTIVE + H_FRONT_PORCH;
    localparam int VS_START = V_ACTIVE + V_FRONT_PORCH;

    logic x_last;
    logic y_last;

    assign x_last = (pixel_x == X_BITS'(H_TOTAL - 1));
    assign y_last = (pixel_y == Y_BITS'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x <= '0;
            pixel_y <= '0;
        end else if (x_last) begin
            pixel_x <= '0;
            pixel_y <= y_last ? '0 : pixel_y + Y_BITS'(1);
        end else begin
            pixel_x <= pixel_x + X_BITS'(1);
        end
    end

    assign active     = (pixel_x < X_BITS'(H_ACTIVE)) && (pixel_y < Y_BITS'(V_ACTIVE));
    assign hsync      = !((pixel_x >= X_BITS'(HS_START)) && (pixel_x < X_BITS'(HS_START + H_SYNC_PULSE)));
    assign vsync      = !((pixel_y >= Y_BITS'(VS_START)) && (pixel_y < Y_BITS'(VS_START + V_SYNC_PULSE)));
    assign frame_wrap = x_last && y_last;

endmodule

// File: rtl/sprite_renderer.sv
// Bouncing, animated, scaled sprite over a solid background; two-stage pixel pipeline.
module sprite_renderer
    import vga_pkg::*;
#(
    parameter int     H_ACTIVE      = VGA_H_ACTIVE,
    parameter int     H_FRONT_PORCH = VGA_H_FP,
    parameter int     H_SYNC_PULSE  = VGA_H_SYNC,
    parameter int     H_BACK_PORCH  = VGA_H_BP,
    parameter int     V_ACTIVE      = VGA_V_ACTIVE,
    parameter int     V_FRONT_PORCH = VGA_V_FP,
    parameter int     V_SYNC_PULSE  = VGA_V_SYNC,
    parameter int     V_BACK_PORCH  = VGA_V_BP,
    parameter int     SPRITE_W      = 34,
    parameter int     SPRITE_H      = 22,
    parameter int     SCALE_BITS    = 3,
    parameter int     NUM_FRAMES    = 2,
    parameter int     FRAME_HOLD    = 16,
    parameter int     START_X       = 128,
    parameter int     START_Y       = 128,
    parameter int     STEP          = 1,
    parameter color_t BG_COLOR      = 6'b000111,
    parameter color_t KEY_COLOR     = 6'b110011
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  pause,
    output logic [((SPRITE_W > 1) ? $clog2(SPRITE_W) : 1)-1:0]    rom_x,
    output logic [((SPRITE_H > 1) ? $clog2(SPRITE_H) : 1)-1:0]    rom_y,
    output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] rom_frame,
    input  logic [5:0]                                            rom_color,
    output logic [7:0]                                            vga_pmod,
    output logic                                                  frame_start
);

    localparam int H_TOTAL   = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int X_BITS    = $clog2(H_TOTAL);
    localparam int Y_BITS    = $clog2(V_TOTAL);
    localparam int RX_BITS   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int RY_BITS   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int RF_BITS   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int HOLD_BITS = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [X_BITS:0] SPR_PX_W = (X_BITS+1)'(SPRITE_W << SCALE_BITS);
    localparam logic [Y_BITS:0] SPR_PX_H = (Y_BITS+1)'(SPRITE_H << SCALE_BITS);
    localparam logic [X_BITS:0] X_MAX    = (X_BITS+1)'(H_ACTIVE - (SPRITE_W << SCALE_BITS));
    localparam logic [Y_BITS:0] Y_MAX    = (Y_BITS+1)'(V_ACTIVE - (SPRITE_H << SCALE_BITS));
    localparam logic [X_BITS:0] STEP_X   = (X_BITS+1)'(STEP);
    localparam logic [Y_BITS:0] STEP_Y   = (Y_BITS+1)'(STEP);

    logic [X_BITS-1:0]    pixel_x;
    logic [Y_BITS-1:0]    pixel_y;
    logic                 active, hsync, vsync, frame_wrap;
    logic [X_BITS-1:0]    sx, dx;
    logic [Y_BITS-1:0]    sy, dy;
    dir_t                 dir_x, dir_y;
    logic [HOLD_BITS-1:0] hold;
    logic [RF_BITS-1:0]   anim_frame;
    logic [X_BITS:0]      sx_inc;
    logic [Y_BITS:0]      sy_inc;
    logic                 in_sprite_c;
    logic                 in_sprite_q, active_q, hsync_q, vsync_q, first_q;
    color_t               color_c;

    vga_timing #(
        .H_ACTIVE      (H_ACTIVE),
        .H_FRONT_PORCH (H_FRONT_PORCH),
        .H_SYNC_PULSE  (H_SYNC_PULSE),
        .H_TOTAL       (H_TOTAL),
        .V_ACTIVE      (V_ACTIVE),
        .V_FRONT_PORCH (V_FRONT_PORCH),
        .V_SYNC_PULSE  (V_SYNC_PULSE),
        .V_TOTAL       (V_TOTAL),
        .X_BITS        (X_BITS),
        .Y_BITS        (Y_BITS)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .active     (active),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_wrap (frame_wrap)
    );

    assign sx_inc = {1'b0, sx} + STEP_X;
    assign sy_inc = {1'b0, sy} + STEP_Y;

    // Position only moves on the frame-wrap edge, so a frame is always drawn at one spot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx         <= X_BITS'(START_X);
            sy         <= Y_BITS'(START_Y);
            dir_x      <= DIR_POS;
            dir_y      <= DIR_POS;
            hold       <= '0;
            anim_frame <= '0;
        end else if (frame_wrap && !pause) begin
            if (dir_x == DIR_POS) begin
                if (sx_inc > X_MAX) begin
                    sx    <= X_MAX[X_BITS-1:0];
                    dir_x <= DIR_NEG;
                end else begin
                    sx <= sx_inc[X_BITS-1:0];
                end
            end else if ({1'b0, sx} < STEP_X) begin
                sx    <= '0;
                dir_x <= DIR_POS;
            end else begin
                sx <= sx - STEP_X[X_BITS-1:0];
            end
            if (dir_y == DIR_POS) begin
                if (sy_inc > Y_MAX) begin
                    sy    <= Y_MAX[Y_BITS-1:0];
                    dir_y <= DIR_NEG;
                end else begin
                    sy <= sy_inc[Y_BITS-1:0];
                end
            end else if ({1'b0, sy} < STEP_Y) begin
                sy    <= '0;
                dir_y <= DIR_POS;
            end else begin
                sy <= sy - STEP_Y[Y_BITS-1:0];
            end
            if (hold == HOLD_BITS'(FRAME_HOLD - 1)) begin
                hold       <= '0;
                anim_frame <= (anim_frame == RF_BITS'(NUM_FRAMES - 1)) ? '0 : anim_frame + RF_BITS'(1);
            end else begin
                hold <= hold + HOLD_BITS'(1);
            end
        end
    end

    // dx/dy wrap when the pixel is left of/above the sprite; the >= guards mask that case.
    assign dx          = pixel_x - sx;
    assign dy          = pixel_y - sy;
    assign in_sprite_c = (pixel_x >= sx) && ({1'b0, dx} < SPR_PX_W) &&
                         (pixel_y >= sy) && ({1'b0, dy} < SPR_PX_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sprite_q <= 1'b0;
            active_q    <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            first_q     <= 1'b0;
            rom_x       <= '0;
            rom_y       <= '0;
            rom_frame   <= '0;
        end else begin
            in_sprite_q <= in_sprite_c;
            active_q    <= active;
            hsync_q     <= hsync;
            vsync_q     <= vsync;
            first_q     <= (pixel_x == '0) && (pixel_y == '0);
            rom_x       <= in_sprite_c ? RX_BITS'(dx >> SCALE_BITS) : '0;
            rom_y       <= in_sprite_c ? RY_BITS'(dy >> SCALE_BITS) : '0;
            rom_frame   <= anim_frame;
        end
    end

    always_comb begin
        color_c = '0;
        if (in_sprite_q && (rom_color != KEY_COLOR)) color_c = rom_color;
        else if (active_q)                           color_c = BG_COLOR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_pmod    <= PMOD_RESET;
            frame_start <= 1'b0;
        end else begin
            vga_pmod    <= pack_pmod(hsync_q, vsync_q, color_c);
            frame_start <= first_q;
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer on a shrunken raster (24x17 total, 16x12 active).
module tb_sprite_renderer;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int SW = 3, SH = 2, SB = 1, NF = 2, FH = 4;
    localparam int SX0 = 9, SY0 = 1, STEP = 1;
    localparam int XMAX = HA - (SW << SB);
    localparam int YMAX = VA - (SH << SB);
    localparam int NFR = 23;
    localparam logic [5:0] BG  = 6'b000111;
    localparam logic [5:0] KEY = 6'b110011;
    localparam logic [5:0] RED = 6'b110000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] rom_x;
    logic       rom_y;
    logic       rom_frame;
    logic [5:0] rom_color;
    logic [7:0] vga_pmod;
    logic       frame_start;

    always #5 clk = ~clk;

    sprite_renderer #(
        .H_ACTIVE(HA), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HBP),
        .V_ACTIVE(VA), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VBP),
        .SPRITE_W(SW), .SPRITE_H(SH), .SCALE_BITS(SB), .NUM_FRAMES(NF), .FRAME_HOLD(FH),
        .START_X(SX0), .START_Y(SY0), .STEP(STEP), .BG_COLOR(BG), .KEY_COLOR(KEY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause),
        .rom_x(rom_x), .rom_y(rom_y), .rom_frame(rom_frame), .rom_color(rom_color),
        .vga_pmod(vga_pmod), .frame_start(frame_start)
    );

    // ROM contents: texel (1,0) is transparent, otherwise colour encodes frame/row/column.
    function automatic logic [5:0] rom_pat(input logic [1:0] tx, input logic ty, input logic f);
        if (tx == 2'd1 && ty == 1'b0) return KEY;
        return {f, ty, tx, 2'b10};
    endfunction

    function automatic logic [7:0] exp_pmod(input logic hs, input logic vs, input logic [5:0] c);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    int mode = 0;
    always_comb begin
        rom_color = RED;
        case (mode)
            1:       rom_color = KEY;
            2:       rom_color = rom_pat(rom_x, rom_y, rom_frame);
            default: rom_color = RED;
        endcase
    end

    typedef struct packed {
        logic [7:0] pmod;
        logic       fs;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] gf;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pops = 0;
    bit   recording = 1'b1;
    int   min_x[NFR];
    int   min_y[NFR];
    int   anim_seen[NFR];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: one output pixel per clock once two pixels are in flight.
    initial begin
        exp_t       e;
        logic [5:0] c;
        forever begin
            @(negedge clk);
            if (rst_n && q.size() >= 2) begin
                e = q.pop_front();
                pops++;
                checks++;
                if ({frame_start, vga_pmod} !== {e.fs, e.pmod}) begin
                    errors++;
                    $display("FAIL pixel (%0d,%0d) frame %0d: vga_pmod=%h frame_start=%b, required %h %b",
                             e.x, e.y, e.gf, vga_pmod, frame_start, e.pmod, e.fs);
                end
                c = {vga_pmod[0], vga_pmod[4], vga_pmod[1], vga_pmod[5], vga_pmod[2], vga_pmod[6]};
                if (recording && e.x < HA && e.y < VA && c != BG && int'(e.gf) < NFR) begin
                    if (int'(e.x) < min_x[e.gf]) min_x[e.gf] = int'(e.x);
                    if (int'(e.y) < min_y[e.gf]) min_y[e.gf] = int'(e.y);
                    anim_seen[e.gf] = int'(c[5]);
                end
            end
        end
    end

    // Hand-derived sprite top-left and animation frame per video frame (99/-1: sprite invisible).
    int hx[NFR] = '{9, 10, 99, 99, 8, 7, 6, 5, 4, 3, 2, 2, 2, 2, 2, 2, 1, 0, 0, 1, 2, 9, 10};
    int hy[NFR] = '{1, 2, 99, 99, 5, 6, 7, 8, 8, 7, 6, 6, 6, 6, 6, 6, 5, 4, 3, 2, 1, 1, 2};
    int ha[NFR] = '{1, 1, -1, -1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        int         mx, my, msx, msy, mdx, mdy, mhold, manim, gf, tx, ty;
        bit         act, ins, hs, vs, wrap;
        logic [5:0] romv, col;
        exp_t       e;

        for (int i = 0; i < NFR; i++) begin
            min_x[i] = 99;
            min_y[i] = 99;
            anim_seen[i] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset vga_pmod", vga_pmod, 8'h88);
        check("reset frame_start", frame_start, 0);
        check("reset rom_x", rom_x, 0);
        check("reset rom_y", rom_y, 0);
        check("reset rom_frame", rom_frame, 0);

        mx = 0; my = 0; msx = SX0; msy = SY0; mdx = 1; mdy = 1; mhold = 0; manim = 0; gf = 0;
        @(negedge clk);
        rst_n = 1'b1;

        while (gf < NFR) begin
            @(posedge clk);
            #1;
            if (gf == 20 && mx == 10 && my == 6) begin
                check("rom_frame before mid-frame reset", rom_frame, 1);
                #2 rst_n = 1'b0;
                #1;
                check("mid reset vga_pmod", vga_pmod, 8'h88);
                check("mid reset frame_start", frame_start, 0);
                check("mid reset rom_x", rom_x, 0);
                check("mid reset rom_y", rom_y, 0);
                check("mid reset rom_frame", rom_frame, 0);
                q.delete();
                mx = 0; my = 0; msx = SX0; msy = SY0; mdx = 1; mdy = 1; mhold = 0; manim = 0;
                gf = 21;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end

            act  = (mx < HA) && (my < VA);
            ins  = (mx >= msx) && (mx < msx + (SW << SB)) && (my >= msy) && (my < msy + (SH << SB));
            tx   = (mx - msx) >>> SB;
            ty   = (my - msy) >>> SB;
            romv = (mode == 0) ? RED : (mode == 1) ? KEY : rom_pat(tx[1:0], ty[0], manim[0]);
            col  = (ins && romv != KEY) ? romv : (act ? BG : 6'b000000);
            hs   = !((mx >= HA + HFP) && (mx < HA + HFP + HS));
            vs   = !((my >= VA + VFP) && (my < VA + VFP + VS));
            e.pmod = exp_pmod(hs, vs, col);
            e.fs   = (mx == 0) && (my == 0);
            e.x    = 8'(mx);
            e.y    = 8'(my);
            e.gf   = 8'(gf);
            q.push_back(e);

            wrap = (mx == HT - 1) && (my == VT - 1);
            if (wrap) begin
                if (!pause) begin
                    if (mdx == 1) begin
                        if (msx + STEP > XMAX) begin msx = XMAX; mdx = 0; end
                        else msx = msx + STEP;
                    end else begin
                        if (msx < STEP) begin msx = 0; mdx = 1; end
                        else msx = msx - STEP;
                    end
                    if (mdy == 1) begin
                        if (msy + STEP > YMAX) begin msy = YMAX; mdy = 0; end
                        else msy = msy + STEP;
                    end else begin
                        if (msy < STEP) begin msy = 0; mdy = 1; end
                        else msy = msy - STEP;
                    end
                    if (mhold == FH - 1) begin
                        mhold = 0;
                        manim = (manim + 1) % NF;
                    end else begin
                        mhold = mhold + 1;
                    end
                end
                gf++;
            end
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            mode  = (gf < 2) ? 0 : (gf < 4) ? 1 : 2;
            pause = (gf >= 10) && (gf <= 14);
        end

        repeat (3) @(posedge clk);
        #1;
        recording = 1'b0;
        for (int i = 0; i < NFR; i++) begin
            check($sformatf("frame %0d sprite left", i), min_x[i], hx[i]);
            check($sformatf("frame %0d sprite top", i), min_y[i], hy[i]);
            check($sformatf("frame %0d anim", i), anim_seen[i], ha[i]);
        end
        check("monitor pixel count above 9000", int'(pops > 9000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
